// File: rtl/neuron_layer_buffer.sv
// neuron_layer_buffer: storage for one fully-connected layer's neuron values.
// Values are loaded through a valid/ready port, either as single addressed
// beats or as an auto-incrementing burst. Reads return a registered window of
// OUTPUT_SZ consecutive neurons. A clear sweep zeroes the layer one entry per
// cycle so it can be refilled between inferences.
module neuron_layer_buffer #(
  parameter int SIZE      = 16,
  parameter int LAYER_SZ  = 10,
  parameter int OUTPUT_SZ = 4,
  parameter int ADDR_W    = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_load_valid,
  output logic                      o_load_ready,
  input  logic                      i_load_burst,
  input  logic [ADDR_W-1:0]         i_load_address,
  input  logic [SIZE-1:0]           i_load_value,
  output logic                      o_load_err,
  input  logic                      i_clear,
  input  logic                      i_rd_req,
  input  logic [ADDR_W-1:0]         i_rd_address,
  output logic [OUTPUT_SZ*SIZE-1:0] o_values,
  output logic                      o_values_valid,
  output logic                      o_layer_full,
  output logic                      o_busy
);

  // Entry index width, and an extended address width one bit wider than the
  // ports so rd_address+i and burst pointer increments never wrap.
  localparam int IDX_W = (LAYER_SZ > 1) ? $clog2(LAYER_SZ) : 1;
  localparam int XW    = ADDR_W + 1;

  localparam logic [XW-1:0]    X_SZ     = XW'(LAYER_SZ);
  localparam logic [XW-1:0]    X_LAST   = XW'(LAYER_SZ - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LAYER_SZ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [XW-1:0]            r_ptr;
  logic [IDX_W-1:0]         r_clr_idx;
  logic [SIZE-1:0]          r_mem [LAYER_SZ];
  logic [LAYER_SZ-1:0]      r_vld;
  logic [OUTPUT_SZ*SIZE-1:0] r_values;
  logic                     r_values_valid;
  logic                     r_load_err;
  logic                     r_layer_full;

  logic                     w_load_ready;
  logic                     w_accept;
  logic [XW-1:0]            w_wr_addr;
  logic                     w_wr_en;
  logic                     w_err;
  logic                     w_rd_accept;
  logic [XW-1:0]            w_idx [OUTPUT_SZ];
  logic [OUTPUT_SZ*SIZE-1:0] w_window;

  // Load handshake, write target selection and next-state decision.
  // NOTE: every signal gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_load_ready = (r_state != ST_CLEAR);
    w_accept     = i_load_valid && w_load_ready;
    w_wr_addr    = (r_state == ST_BURST) ? r_ptr : {1'b0, i_load_address};
    w_wr_en      = w_accept && (w_wr_addr < X_SZ);
    w_err        = w_accept && !w_wr_en;
    w_rd_accept  = i_rd_req && (r_state != ST_CLEAR);

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          // A burst starting on the last entry is complete after one beat.
          if (i_load_burst && w_wr_en && (w_wr_addr != X_LAST)) begin
            w_next_state = ST_BURST;
          end
        end else if (i_clear) begin
          w_next_state = ST_CLEAR;
        end
      end
      ST_BURST: begin
        if (w_accept && (r_ptr == X_LAST)) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (r_clr_idx == IDX_LAST) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Read window: slots beyond the last entry read as zero, no wrap.
  always_comb begin
    w_window = '0;
    for (int i = 0; i < OUTPUT_SZ; i++) begin
      w_idx[i] = {1'b0, i_rd_address} + XW'(i);
      if (w_idx[i] < X_SZ) begin
        w_window[i*SIZE +: SIZE] = r_mem[w_idx[i][IDX_W-1:0]];
      end
    end
  end

  // State register, burst pointer and clear-sweep index.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_wr_en) begin
        r_ptr <= w_wr_addr + XW'(1);
      end
      if (r_state == ST_CLEAR) begin
        r_clr_idx <= (r_clr_idx == IDX_LAST) ? '0 : r_clr_idx + IDX_W'(1);
      end
    end
  end

  // Entry storage and valid bits: written by loads, zeroed by the sweep.
  // NOTE: the array is built from flops and reset explicitly because a reset
  // must leave every entry reading zero; a RAM macro could not do that.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < LAYER_SZ; k++) begin
        r_mem[k] <= '0;
      end
      r_vld <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_mem[r_clr_idx] <= '0;
      r_vld[r_clr_idx] <= 1'b0;
    end else if (w_wr_en) begin
      r_mem[w_wr_addr[IDX_W-1:0]] <= i_load_value;
      r_vld[w_wr_addr[IDX_W-1:0]] <= 1'b1;
    end
  end

  // Registered outputs: read window, its valid pulse, error pulse, full flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_values       <= '0;
      r_values_valid <= 1'b0;
      r_load_err     <= 1'b0;
      r_layer_full   <= 1'b0;
    end else begin
      r_values_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_values <= w_window;
      end
      r_load_err   <= w_err;
      r_layer_full <= &r_vld;
    end
  end

  assign o_load_ready   = w_load_ready;
  assign o_load_err     = r_load_err;
  assign o_values       = r_values;
  assign o_values_valid = r_values_valid;
  assign o_layer_full   = r_layer_full;
  assign o_busy         = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_neuron_layer_buffer.sv
// Directed testbench for neuron_layer_buffer. Read windows are checked by a
// scoreboard: each read pushes its expected window and a monitor pops and
// compares whenever values_valid is seen. Status flags are checked inline.
module tb_neuron_layer_buffer;

  localparam int SIZE      = 16;
  localparam int LAYER_SZ  = 10;
  localparam int OUTPUT_SZ = 4;
  localparam int ADDR_W    = 16;
  localparam int VW        = OUTPUT_SZ * SIZE;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_valid;
  logic              load_ready;
  logic              load_burst;
  logic [ADDR_W-1:0] load_address;
  logic [SIZE-1:0]   load_value;
  logic              load_err;
  logic              clear;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_address;
  logic [VW-1:0]     values;
  logic              values_valid;
  logic              layer_full;
  logic              busy;

  logic [VW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neuron_layer_buffer #(
    .SIZE(SIZE), .LAYER_SZ(LAYER_SZ), .OUTPUT_SZ(OUTPUT_SZ), .ADDR_W(ADDR_W)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_load_valid(load_valid),
    .o_load_ready(load_ready),
    .i_load_burst(load_burst),
    .i_load_address(load_address),
    .i_load_value(load_value),
    .o_load_err(load_err),
    .i_clear(clear),
    .i_rd_req(rd_req),
    .i_rd_address(rd_address),
    .o_values(values),
    .o_values_valid(values_valid),
    .o_layer_full(layer_full),
    .o_busy(busy)
  );

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [SIZE-1:0] v, input logic b);
    load_valid   = 1'b1;
    load_address = a;
    load_value   = v;
    load_burst   = b;
    tick();
    load_valid = 1'b0;
    load_burst = 1'b0;
  endtask

  task automatic read(input logic [ADDR_W-1:0] a, input logic [VW-1:0] e);
    rd_req     = 1'b1;
    rd_address = a;
    exp_q.push_back(e);
    tick();
    rd_req = 1'b0;
  endtask

  // Monitor: every values_valid pulse must match the oldest expected window.
  always @(negedge clk) begin
    if (values_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_values_valid: got values %h with no read pending", values);
      end else begin
        check("values_window", values, exp_q.pop_front());
      end
    end
  end

  initial begin
    int cnt;
    reset        = 1'b1;
    load_valid   = 1'b0;
    load_burst   = 1'b0;
    load_address = '0;
    load_value   = '0;
    clear        = 1'b0;
    rd_req       = 1'b0;
    rd_address   = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    check("rst_values", values, '0);
    check("rst_values_valid", values_valid, 0);
    check("rst_load_err", load_err, 0);
    check("rst_layer_full", layer_full, 0);
    check("rst_busy", busy, 0);
    check("rst_load_ready", load_ready, 1);

    // Fill all entries with single loads: entry k <- 0x0100+k.
    for (int k = 0; k < LAYER_SZ; k++) begin
      load(ADDR_W'(k), SIZE'(16'h0100 + k), 1'b0);
    end
    tick();
    check("full_after_fill", layer_full, 1);
    read(16'd3, 64'h0106_0105_0104_0103);
    tick();
    check("values_valid_pulse", values_valid, 0);

    // Burst from 6 with toggled valid; junk addresses must be ignored.
    load(16'd6, 16'h00A0, 1'b1);
    tick();
    load(16'd1, 16'h00A1, 1'b0);
    tick();
    load(16'd2, 16'h00A2, 1'b0);
    load(16'd3, 16'h00A3, 1'b0);
    // Burst is over: this is a plain addressed load to entry 0.
    load(16'd0, 16'h0BEE, 1'b0);
    check("burst_end_no_err", load_err, 0);
    read(16'd6, 64'h00A3_00A2_00A1_00A0);
    read(16'd0, 64'h0103_0102_0101_0BEE);

    // Window boundaries, back-to-back reads.
    read(16'd8, 64'h0000_0000_00A3_00A2);
    read(16'hFFFF, 64'h0);
    read(16'd9, 64'h0000_0000_0000_00A3);

    // Out-of-range single load: dropped with a one-cycle error pulse.
    load(16'd12, 16'hDEAD, 1'b0);
    check("err_pulse_high", load_err, 1);
    tick();
    check("err_pulse_low", load_err, 0);
    check("full_after_err", layer_full, 1);
    read(16'd8, 64'h0000_0000_00A3_00A2);

    // Same-cycle read and write of entry 2: read returns the old value.
    load_valid   = 1'b1;
    load_address = 16'd2;
    load_value   = 16'h0055;
    rd_req       = 1'b1;
    rd_address   = 16'd2;
    exp_q.push_back(64'h0105_0104_0103_0102);
    tick();
    load_valid = 1'b0;
    rd_req     = 1'b0;
    read(16'd2, 64'h0105_0104_0103_0055);

    // Clear together with a load: the load wins, no sweep starts.
    clear = 1'b1;
    load(16'd7, 16'h0077, 1'b0);
    clear = 1'b0;
    check("clear_vs_load_busy0", busy, 0);
    tick();
    check("clear_vs_load_busy1", busy, 0);
    read(16'd6, 64'h00A3_00A2_0077_00A0);

    // Full clear sweep: busy for LAYER_SZ cycles, reads ignored.
    check("full_before_clear", layer_full, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      if (cnt == 0) check("load_ready_in_clear", load_ready, 0);
      rd_req     = 1'b1;
      rd_address = 16'd0;
      cnt++;
      tick();
    end
    rd_req = 1'b0;
    check("clear_cycles", VW'(cnt), VW'(LAYER_SZ));
    check("full_after_clear", layer_full, 0);
    check("ready_after_clear", load_ready, 1);
    read(16'd0, 64'h0);
    read(16'd6, 64'h0);

    // Reset in the middle of a burst: aborts it and zeroes the entries.
    load(16'd3, 16'h0033, 1'b1);
    load(16'd0, 16'h0044, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midburst_rst_values", values, '0);
    check("midburst_rst_busy", busy, 0);
    load(16'd0, 16'h0099, 1'b0);
    read(16'd0, 64'h0000_0000_0000_0099);
    read(16'd3, 64'h0);

    // Drain the scoreboard with a bounded wait.
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
    check("scoreboard_drained", VW'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
